softmax_backward_layer: RTL

- Backward-pass counterpart of the forward softmax layer in the training datapath.
- Takes the N per-token softmax probability rows and the N target character indices.
- Emits the cross-entropy gradient dL/dz = (p - onehot(label)) >> SHIFT for each row, plus a per-row top-1 hit flag.
- Columns are swept serially, one column index per cycle across all N rows in parallel. The result feeds the backward path of the preceding dense layer.

---
 rtl/softmax_backward_layer_if.sv | 47 ++++
 rtl/softmax_backward_layer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/softmax_backward_layer_if.sv
// -----------------------------------------------------------------------------
// softmax_backward_layer_if
//
// Purpose: groups the data and control signals of the softmax backward layer
// into one bundle so producer and consumer see a single port.
//
// Signals:
//   run        - level request; high = sweep / hold result, low = go idle
//   load_d_num - load the per-row labels from d_num on this clock edge
//   d          - N rows x CHAR_NUM softmax probabilities (signed N_LEN each)
//   d_num      - N target indices, CHAR_LEN bits each
//   valid      - q and hit hold a complete result
//   q          - N rows x CHAR_NUM signed gradients, same packing as d
//   hit        - per-row top-1 hit flag
//   dbg_state  - current FSM state of the layer
//
// Handshake: there is no ready. The master raises run and holds run, d and
// d_num stable until it has consumed the result. The slave raises valid once
// q and hit are complete and keeps it high for as long as run stays high.
// Dropping run ends the transaction; valid falls one cycle after the layer
// returns to idle, while q and hit keep their last values.
// -----------------------------------------------------------------------------
interface softmax_backward_layer_if #(
    parameter int N        = 2,
    parameter int CHAR_NUM = 16,
    parameter int CHAR_LEN = 5,
    parameter int N_LEN    = 16
);
    logic                         run;
    logic                         load_d_num;
    logic [N*CHAR_NUM*N_LEN-1:0]  d;
    logic [N*CHAR_LEN-1:0]        d_num;
    logic                         valid;
    logic [N*CHAR_NUM*N_LEN-1:0]  q;
    logic [N-1:0]                 hit;
    logic [1:0]                   dbg_state;

    modport master (
        output run, load_d_num, d, d_num,
        input  valid, q, hit, dbg_state
    );

    modport slave (
        input  run, load_d_num, d, d_num,
        output valid, q, hit, dbg_state
    );
endinterface

// File: rtl/softmax_backward_layer.sv
// -----------------------------------------------------------------------------
// softmax_backward_layer
//
// Purpose: backward pass of the softmax + cross-entropy stage. For every row
// i and column j it produces q[i][j] = (p[i][j] - onehot(label[i])[j]) >>> SHIFT
// and a top-1 hit flag (argmax(p[i]) == label[i]). Columns are swept one per
// cycle, all N rows in parallel.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of softmax_backward_layer_if (run, load_d_num, d,
//           d_num in; valid, q, hit, dbg_state out)
//
// Timing: run sampled high at edge 0, columns 0..CHAR_NUM-1 are processed
// on edges 1..CHAR_NUM, valid is high after edge CHAR_NUM+1.
// -----------------------------------------------------------------------------
module softmax_backward_layer #(
    parameter int N        = 2,
    parameter int CHAR_NUM = 16,
    parameter int CHAR_LEN = 5,
    parameter int N_LEN    = 16,
    parameter int F_LEN    = N_LEN / 2,
    parameter int SHIFT    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    softmax_backward_layer_if.slave bus
);

    localparam int COL_W = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1;
    localparam logic signed [N_LEN-1:0] ONE      = N_LEN'(1) << F_LEN;
    localparam logic        [COL_W-1:0] LAST_COL = COL_W'(CHAR_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [CHAR_LEN-1:0]         label_q [N];
    logic [CHAR_LEN-1:0]         label_d [N];
    logic signed [N_LEN-1:0]     max_q   [N];
    logic signed [N_LEN-1:0]     max_d   [N];
    logic [COL_W-1:0]            amax_q  [N];
    logic [COL_W-1:0]            amax_d  [N];
    logic [N*CHAR_NUM*N_LEN-1:0] q_q, q_d;
    logic [N-1:0]                hit_q, hit_d;
    logic                        valid_q, valid_d;

    logic signed [N_LEN-1:0]     p_col [N];
    logic signed [N_LEN-1:0]     grad  [N];
    logic                        last_col;
    logic                        calc_en;

    assign last_col = (col_q == LAST_COL);
    // A column is only written while run is still high; dropping run in CALC
    // aborts without touching the current column.
    assign calc_en  = (state_q == S_CALC) && bus.run;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_CALC;
            S_CALC: begin
                if (!bus.run)      state_d = S_IDLE;
                else if (last_col) state_d = S_DONE;
            end
            S_DONE: if (!bus.run) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        bus.valid     = valid_q;
        bus.q         = q_q;
        bus.hit       = hit_q;
        bus.dbg_state = state_q;
    end

    // ------------------------------------------------------ column muxes
    // One element per row at the current column; a label outside the
    // column range never equals col_q, so padding rows get no onehot term.
    always_comb begin : col_mux
        for (int i = 0; i < N; i++) begin
            p_col[i] = bus.d[(i*CHAR_NUM + int'(col_q))*N_LEN +: N_LEN];
            if (32'(label_q[i]) == 32'(col_q)) begin
                grad[i] = (p_col[i] - ONE) >>> SHIFT;
            end else begin
                grad[i] = p_col[i] >>> SHIFT;
            end
        end
    end

    // ---------------------------------------------------- datapath next
    always_comb begin : datapath_next
        col_d   = '0;
        q_d     = q_q;
        hit_d   = hit_q;
        // Registered from the state, so valid trails DONE entry and exit by
        // one cycle.
        valid_d = (state_q == S_DONE);
        for (int i = 0; i < N; i++) begin
            label_d[i] = bus.load_d_num ? bus.d_num[i*CHAR_LEN +: CHAR_LEN]
                                        : label_q[i];
            max_d[i]   = max_q[i];
            amax_d[i]  = amax_q[i];
        end

        if (calc_en) begin
            col_d = last_col ? '0 : col_q + COL_W'(1);
            for (int i = 0; i < N; i++) begin
                q_d[(i*CHAR_NUM + int'(col_q))*N_LEN +: N_LEN] = grad[i];
                // Column 0 reseeds the running max; strict compare keeps
                // the lowest index on ties.
                if ((col_q == '0) || (p_col[i] > max_q[i])) begin
                    max_d[i]  = p_col[i];
                    amax_d[i] = col_q;
                end
                // Hit uses the argmax including the final column.
                if (last_col) begin
                    hit_d[i] = (32'(amax_d[i]) == 32'(label_q[i]));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath_reg
        if (!rst_n) begin
            col_q   <= '0;
            q_q     <= '0;
            hit_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                label_q[i] <= '0;
                max_q[i]   <= '0;
                amax_q[i]  <= '0;
            end
        end else begin
            col_q   <= col_d;
            q_q     <= q_d;
            hit_q   <= hit_d;
            valid_q <= valid_d;
            for (int i = 0; i < N; i++) begin
                label_q[i] <= label_d[i];
                max_q[i]   <= max_d[i];
                amax_q[i]  <= amax_d[i];
            end
        end
    end

endmodule
